// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg
//   Shared types for the ALU write-back stage: ALU opcode enum, data and PC
//   types, the buffered write-back entry, and the opcode classification
//   helper that decides whether an instruction writes its destination.
package alu_writeback_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int PC_STEP = 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] instruction_memory_address_t;

  // Encodings 16..31 are unassigned and treated as unknown (no write, no redirect).
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_ABS  = 5'd4,
    OP_SLT  = 5'd5,
    OP_SEQ  = 5'd6,
    OP_SNEZ = 5'd7,
    OP_MIN  = 5'd8,
    OP_SLL  = 5'd9,
    OP_ADDI = 5'd10,
    OP_MULI = 5'd11,
    OP_DIVI = 5'd12,
    OP_SLLI = 5'd13,
    OP_JAL  = 5'd14,
    OP_BEQZ = 5'd15
  } alu_instruction_t;

  typedef struct packed {
    alu_instruction_t            instr;
    instruction_memory_address_t pc;
    data_t                       imm;
    data_t                       result;
    logic [REG_AW-1:0]           rd;
  } wb_entry_t;

  function automatic logic writes_rd(input alu_instruction_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ABS, OP_SLT, OP_SEQ, OP_SNEZ,
      OP_MIN, OP_SLL, OP_ADDI, OP_MULI, OP_DIVI, OP_SLLI, OP_JAL: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_skid_buffer.sv
// wb_skid_buffer
//   Two-entry in-order FIFO of wb_entry_t sitting between the ALU pipeline
//   register and the register-file write port.
// Ports:
//   clk, rst_n       clock, async active-low reset (control state only)
//   push, push_entry enqueue an entry (caller guarantees not_full)
//   pop              dequeue the head (caller guarantees head_valid)
//   clear            drop every entry; dominates push and pop
//   head_valid       at least one entry held
//   head_entry       oldest entry
//   not_full         registered, derived from the post-edge occupancy
module wb_skid_buffer
  import alu_writeback_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output logic      head_valid,
  output wb_entry_t head_entry,
  output logic      not_full
);

  logic [1:0] count_q, count_d;
  logic       not_full_q, not_full_d;
  wb_entry_t  e0_q, e0_d;
  wb_entry_t  e1_q, e1_d;

  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_entry;
          else                 e1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        // Push and pop together only happens at occupancy 1: new entry becomes head.
        2'b11: begin
          e0_d = push_entry;
        end
        default: ;
      endcase
    end
    not_full_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  // Payload storage needs no reset: it is only observed while count_q says valid.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

  assign head_valid = (count_q != 2'd0);
  assign head_entry = e0_q;
  assign not_full   = not_full_q;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback
//   Retires ALU results: writes the register file, resolves JAL / taken BEQZ
//   into a one-cycle PC redirect, squashes wrong-path entries, and counts
//   retired instructions. A 2-entry skid buffer absorbs write-port stalls.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop all buffered entries at the edge
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_instr..in_rd     instruction context and ALU result
//   rf_we/waddr/wdata   register-file write request (addr/data hold when idle)
//   wb_ready            register-file port grants the write this cycle
//   redirect_valid/pc   fetch redirect pulse and target (target holds)
//   retired_count       instructions retired since reset
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  alu_instruction_t            in_instr,
  input  instruction_memory_address_t in_pc,
  input  data_t                       in_imm,
  input  data_t                       in_result,
  input  logic [REG_AW-1:0]           in_rd,
  output logic                        rf_we,
  output logic [REG_AW-1:0]           rf_waddr,
  output data_t                       rf_wdata,
  input  logic                        wb_ready,
  output logic                        redirect_valid,
  output instruction_memory_address_t redirect_pc,
  output logic [CNT_W-1:0]            retired_count
);

  wb_entry_t push_entry, head;
  logic      head_valid, not_full, push, retire, redirect, writes;
  logic      is_jal, beqz_taken;

  instruction_memory_address_t target, link;
  data_t                       wdata_now;

  logic [REG_AW-1:0]           waddr_q, waddr_d;
  data_t                       wdata_q, wdata_d;
  instruction_memory_address_t redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]            retired_q, retired_d;

  assign push_entry = '{instr: in_instr, pc: in_pc, imm: in_imm, result: in_result, rd: in_rd};
  assign push       = in_valid && not_full;

  // A redirect squashes everything behind the retiring branch, including a
  // same-edge acceptance, so it shares the clear path with flush.
  wb_skid_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (retire),
    .clear      (flush || redirect),
    .head_valid (head_valid),
    .head_entry (head),
    .not_full   (not_full)
  );

  always_comb begin
    writes     = head_valid && writes_rd(head.instr) && (head.rd != '0);
    is_jal     = (head.instr == OP_JAL);
    beqz_taken = (head.instr == OP_BEQZ) && (head.result == data_t'(1));
    retire     = head_valid && (!writes || wb_ready);
    redirect   = retire && (is_jal || beqz_taken);
    link       = head.pc + ADDR_W'(PC_STEP);
    target     = is_jal ? head.result[ADDR_W-1:0] : head.pc + head.imm[ADDR_W-1:0];
    wdata_now  = is_jal ? DATA_W'(link) : head.result;
    waddr_d    = writes   ? head.rd   : waddr_q;
    wdata_d    = writes   ? wdata_now : wdata_q;
    redir_pc_d = redirect ? target    : redir_pc_q;
    retired_d  = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q    <= '0;
      wdata_q    <= '0;
      redir_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      redir_pc_q <= redir_pc_d;
      retired_q  <= retired_d;
    end
  end

  assign in_ready       = not_full;
  assign rf_we          = writes;
  assign rf_waddr       = waddr_d;
  assign rf_wdata       = wdata_d;
  assign redirect_valid = redirect;
  assign redirect_pc    = redir_pc_d;
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback
//   Directed bench for alu_writeback. Expected register-file writes and
//   redirects are queued as stimulus is issued; a monitor pops and compares
//   whenever the DUT grants a write or pulses a redirect.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic                        clk, rst_n, flush, in_valid, in_ready, wb_ready;
  alu_instruction_t            in_instr;
  instruction_memory_address_t in_pc, redirect_pc;
  data_t                       in_imm, in_result, rf_wdata;
  logic [REG_AW-1:0]           in_rd, rf_waddr;
  logic                        rf_we, redirect_valid;
  logic [31:0]                 retired_count;

  int n_vec  = 0;
  int n_fail = 0;

  logic [36:0] exp_w[$];   // {rd, data}
  logic [31:0] exp_r[$];   // redirect target

  alu_writeback #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_result      (in_result),
    .in_rd          (in_rd),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .wb_ready       (wb_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .retired_count  (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input alu_instruction_t op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] res, input logic [4:0] rd);
    in_valid  = v;
    in_instr  = op;
    in_pc     = pc;
    in_imm    = imm;
    in_result = res;
    in_rd     = rd;
  endtask

  task automatic issue(input alu_instruction_t op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] res, input logic [4:0] rd);
    drive(1'b1, op, pc, imm, res, rd);
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rf_we && wb_ready) begin
      if (exp_w.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h, want no write", rf_waddr, rf_wdata);
      end else begin
        check("wb_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, exp_w.pop_front()});
      end
    end
    if (rst_n && redirect_valid) begin
      if (exp_r.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_redirect: got pc=0x%0h, want no redirect", redirect_pc);
      end else begin
        check("redirect_pc", {32'd0, redirect_pc}, {32'd0, exp_r.pop_front()});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b1;
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_retired", retired_count, 0);
    rst_n = 1'b1;
    tick();

    // Simple ALU write
    exp_w.push_back({5'd3, 32'h10});
    issue(OP_ADD, 32'h0, 32'h0, 32'h10, 5'd3);
    @(negedge clk);
    check("add_in_ready", in_ready, 1);
    check("add_rf_we", rf_we, 1);
    tick();
    @(negedge clk);
    check("add_retired", retired_count, 1);
    check("add_idle_we", rf_we, 0);

    // rd==0 never writes but still retires
    issue(OP_ADDI, 32'h4, 32'h5, 32'h5, 5'd0);
    @(negedge clk);
    check("rd0_rf_we", rf_we, 0);
    check("rd0_redirect", redirect_valid, 0);
    tick();
    @(negedge clk);
    check("rd0_retired", retired_count, 2);
    check("hold_waddr", rf_waddr, 3);
    check("hold_wdata", rf_wdata, 32'h10);

    // Unknown opcode: no write
    issue(alu_instruction_t'(5'd31), 32'h8, 32'h0, 32'hAB, 5'd2);
    @(negedge clk);
    check("unk_rf_we", rf_we, 0);
    tick();
    @(negedge clk);
    check("unk_retired", retired_count, 3);

    // Back-pressure: three writes while the port is busy
    wb_ready = 1'b0;
    exp_w.push_back({5'd4, 32'h100});
    exp_w.push_back({5'd5, 32'h200});
    exp_w.push_back({5'd6, 32'h300});
    issue(OP_ADD, 32'h10, 32'h0, 32'h100, 5'd4);
    issue(OP_SUB, 32'h11, 32'h0, 32'h200, 5'd5);
    drive(1'b1, OP_MUL, 32'h12, 32'h0, 32'h300, 5'd6);
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_rf_we", rf_we, 1);
    check("stall_waddr", rf_waddr, 4);
    check("stall_wdata", rf_wdata, 32'h100);
    tick();
    @(negedge clk);
    check("stall2_in_ready", in_ready, 0);
    check("stall2_waddr", rf_waddr, 4);
    check("stall2_wdata", rf_wdata, 32'h100);
    tick();
    wb_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("drain_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("drain2_in_ready", in_ready, 1);
    tick();
    @(negedge clk);
    check("drain_retired", retired_count, 6);
    check("drain_idle_we", rf_we, 0);

    // JAL with an entry queued behind it
    wb_ready = 1'b0;
    exp_w.push_back({5'd1, 32'h21});
    exp_r.push_back(32'h40);
    issue(OP_JAL, 32'h20, 32'h0, 32'h40, 5'd1);
    issue(OP_ADD, 32'h21, 32'h0, 32'h77, 5'd7);
    @(negedge clk);
    check("jal_stall_in_ready", in_ready, 0);
    check("jal_stall_redirect", redirect_valid, 0);
    tick();
    wb_ready = 1'b1;
    @(negedge clk);
    check("jal_redirect_valid", redirect_valid, 1);
    tick();
    @(negedge clk);
    check("jal_post_redirect", redirect_valid, 0);
    check("jal_post_we", rf_we, 0);
    check("jal_post_in_ready", in_ready, 1);
    check("jal_retired", retired_count, 7);

    // Taken BEQZ with wrapping target and a same-edge acceptance
    exp_r.push_back(32'h2);
    issue(OP_BEQZ, 32'hFFFF_FFFE, 32'h4, 32'h1, 5'd0);
    drive(1'b1, OP_ADD, 32'h50, 32'h0, 32'h88, 5'd8);
    @(negedge clk);
    check("beqz_redirect_valid", redirect_valid, 1);
    check("beqz_rf_we", rf_we, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("beqz_post_redirect", redirect_valid, 0);
    check("beqz_squash_we", rf_we, 0);
    check("beqz_retired", retired_count, 8);

    // Not-taken BEQZ
    issue(OP_BEQZ, 32'h30, 32'h8, 32'h0, 5'd0);
    @(negedge clk);
    check("beqz_nt_redirect", redirect_valid, 0);
    tick();
    @(negedge clk);
    check("beqz_nt_retired", retired_count, 9);
    check("hold_redirect_pc", redirect_pc, 32'h2);

    // Flush at occupancy 2
    wb_ready = 1'b0;
    issue(OP_ADD, 32'h60, 32'h0, 32'h99, 5'd9);
    issue(OP_ADD, 32'h61, 32'h0, 32'hAA, 5'd10);
    @(negedge clk);
    check("pre_flush_in_ready", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", in_ready, 1);
    check("flush_rf_we", rf_we, 0);
    check("flush_redirect", redirect_valid, 0);
    check("flush_retired", retired_count, 9);

    // Reset mid-stall
    issue(OP_ADD, 32'h70, 32'h0, 32'hBB, 5'd11);
    issue(OP_ADD, 32'h71, 32'h0, 32'hCC, 5'd12);
    rst_n = 1'b0;
    #2;
    check("midrst_rf_we", rf_we, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_retired", retired_count, 0);
    check("midrst_waddr", rf_waddr, 0);
    check("midrst_wdata", rf_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wb_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("postrst_rf_we", rf_we, 0);
    check("postrst_retired", retired_count, 0);

    check("pending_writes", exp_w.size(), 0);
    check("pending_redirects", exp_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream neighbour of the ALU: consumes the combinational ALU Result together with its instruction context.
- Retires one instruction per cycle: writes the register file and resolves control flow (BEQZ taken / JAL) into a PC redirect.
- A 2-entry skid buffer decouples the ALU pipeline register from register-file port back-pressure.
- Issues squash signalling for wrong-path work.

Parameters:
- ADDR_W, 32, width of instruction_memory_address_t (PC).
- DATA_W, 32, width of data_t.
- REG_AW, 5, register index width.
- PC_STEP, 1, PC increment per instruction (word-addressed instruction memory).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  external pipeline flush; discards all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  buffer can accept; registered (function of occupancy only).
- in_instr  in  alu_instruction_t  opcode executed by ALU.
- in_pc  in  ADDR_W  PC of instruction.
- in_imm  in  DATA_W  immediate.
- in_result  in  DATA_W  ALU Result.
- in_rd  in  REG_AW  destination register.
- rf_we  out  1  register-file write request.
- rf_waddr  out  REG_AW  write index.
- rf_wdata  out  DATA_W  write data.
- wb_ready  in  1  register-file port grants write this cycle.
- redirect_valid  out  1  one-cycle pulse: fetch must jump.
- redirect_pc  out  ADDR_W  jump target.
- retired_count  out  CNT_W  instructions retired since reset.

Behaviour:
- Reset (async, rst_n=0): buffer empty, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, redirect_valid=0, redirect_pc=0, retired_count=0.
- Acceptance: entry accepted on a clk edge where in_valid && in_ready. Entries are stored in order; occupancy is 0..2.
- in_ready = (occupancy < 2), registered from the post-edge occupancy.
- Head entry outputs are combinational from the head register. Accept-to-output latency is 1 cycle.
- Write classification:
  - Writes rd: ADD, SUB, MUL, DIV, ABS, SLT, SEQ, SNEZ, MIN, SLL, ADDI, MULI, DIVI, SLLI, JAL.
  - Does not write: BEQZ, all unknown opcodes.
  - No write when rd==0.
- rf_we = head_valid && writes. rf_waddr = head rd.
- rf_wdata:
  - result for ALU ops.
  - For JAL: link = pc + PC_STEP, zero-extended to DATA_W.
  - When rf_we=0, rf_waddr/rf_wdata hold their last values.
- Retire condition: head_valid && (!writes || wb_ready). On retire, the head pops and retired_count increments (wraps at 2^CNT_W).
- Control flow:
  - JAL retire: redirect_valid=1, redirect_pc=result[ADDR_W-1:0].
  - BEQZ retire with result==1: redirect_valid=1, redirect_pc = pc + imm[ADDR_W-1:0], modulo 2^ADDR_W.
  - BEQZ with result==0: retires silently.
  - redirect_valid is combinational with the retire; it is high for exactly one cycle per taken branch.
- Squash on a redirect retire: the second buffer entry (if any) and any entry accepted at that same edge are discarded. Post-edge occupancy is 0 and these entries are not counted.
- flush=1: occupancy goes to 0 at the edge; any same-edge acceptance is dropped.
  - rf_we and redirect_valid are still gated by the current head during the flush cycle: an in-flight write completes if wb_ready=1.
  - flush does not affect retired_count except for that retire.
- Simultaneous accept and retire at occupancy 2: impossible, since in_ready=0.
- Simultaneous accept and retire at occupancy 1: occupancy stays 1, new entry becomes head.
- Stall: wb_ready=0 with a writing head holds all outputs stable until granted.
- Reset mid-operation: all entries lost immediately; no write or redirect issued.

Decomposition:
- Shared package (common.svh):
  - alu_instruction_t
  - data_t
  - instruction_memory_address_t
  - a new wb_entry_t struct {instr, pc, imm, result, rd}
  - PC_STEP constant
  - a function writes_rd(alu_instruction_t)
- One sub-module: wb_skid_buffer — 2-entry FIFO of wb_entry_t with push, pop, clear, and registered not_full.
- Classification, redirect and counter logic live in alu_writeback.

Test Plan:
- Reset, then ADD rd=3 result=0x10, wb_ready=1 → next cycle rf_we=1, waddr=3, wdata=0x10; retired_count=1; in_ready stays 1.
- ADDI rd=0 result=5 → rf_we=0, retires immediately, no redirect.
- wb_ready=0 for 3 cycles with 3 back-to-back writes → in_ready drops after 2 accepted; outputs stable; on release, writes retire in order one per cycle.
- JAL pc=0x20 result=0x40 rd=1 → rf_wdata=0x21, redirect_valid pulse with redirect_pc=0x40; entry queued behind it and the same-cycle acceptance are discarded; count +1 only.
- BEQZ pc=0xFFFFFFFE imm=4 result=1 → redirect_pc=0x00000002 (wrap); BEQZ with result=0 → no redirect.
- Assert flush with occupancy 2 and rst_n low mid-stall → buffer empty next cycle, in_ready=1, no spurious rf_we or redirect_valid.
